// File: rtl/piano_synth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piano_pkg
//  Description : Note table, FSM state type and sizing helper for piano_synth.
//  Revision    : 1.0 - initial release
// ============================================================================
package piano_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        SUSTAIN = 2'd2,
        STOP    = 2'd3
    } state_t;

    // Entry 0 is the lowest note (key 0); element [i] is the half-period of key i.
    localparam logic [7:0][15:0] HALF_PERIOD = {
        16'd955, 16'd1012, 16'd1136, 16'd1275,
        16'd1431, 16'd1516, 16'd1702, 16'd1911
    };

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [15:0] table_hp(input logic [2:0] idx);
        return HALF_PERIOD[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/piano_synth_tone_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tone_divider
//  Description : Half-period counter producing a square tone; relatches the
//                half-period only when starting and on each toggle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_divider #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [CNT_W-1:0] hp_in,
    output logic             tone,
    output logic             toggle
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hp_l;
    logic             r_tone;

    assign toggle = run && (r_cnt == r_hp_l);
    assign tone   = r_tone;

    // While stopped the divider holds the next half-period ready so that the
    // first half after start is already correct.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_hp_l <= '0;
            r_tone <= 1'b0;
        end else if (!run) begin
            r_cnt  <= '0;
            r_hp_l <= hp_in;
            r_tone <= 1'b0;
        end else if (toggle) begin
            r_cnt  <= '0;
            r_hp_l <= hp_in;
            r_tone <= ~r_tone;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/piano_synth.sv
`default_nettype none
// ============================================================================
//  Module      : piano_synth
//  Description : Multi-key piezo tone generator with priority, octave shift,
//                glitch-free note changes and an optional sustain tail.
//  Revision    : 1.0 - initial release
// ============================================================================
module piano_synth
    import piano_pkg::*;
#(
    parameter int NUM_KEYS    = 8,
    parameter int CNT_W       = 16,
    parameter int SUSTAIN_CYC = 2_000_000,
    parameter int SUS_W       = 22,
    localparam int IDX_W      = idx_w(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic [1:0]          octave,
    input  logic                sustain_en,
    input  logic                mute,
    output logic                piezo,
    output logic                active,
    output logic [IDX_W-1:0]    note_idx
);
    localparam logic [SUS_W-1:0] c_sus_last = SUS_W'(SUSTAIN_CYC - 1);

    state_t              r_state;
    logic [NUM_KEYS-1:0] r_key_q;
    logic                r_mute_q;
    logic                r_piezo;
    logic                r_active;
    logic [IDX_W-1:0]    r_note_idx;
    logic [SUS_W-1:0]    r_sus;

    logic                w_any_key;
    logic                w_run;
    logic                w_tone;
    logic                w_toggle;
    logic                w_tone_next;
    logic                w_load;
    logic [IDX_W-1:0]    w_sel;
    logic [IDX_W-1:0]    w_idx;
    logic [15:0]         w_hp_raw;
    logic [CNT_W-1:0]    w_hp_in;

    assign w_any_key = |r_key_q;

    always_comb begin
        w_sel = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (r_key_q[i]) w_sel = IDX_W'(i);
        end
    end

    // Without a pressed key (sustain/stop tail) the latched note keeps playing.
    assign w_idx  = (w_any_key && (r_state == IDLE || r_state == PLAY)) ? w_sel : r_note_idx;
    assign w_load = ((r_state == IDLE) && w_any_key) || w_toggle;

    always_comb begin
        w_hp_raw = table_hp(3'(w_idx)) >> octave;
        w_hp_in  = (w_hp_raw == 16'd0) ? CNT_W'(1) : CNT_W'(w_hp_raw);
    end

    // Dropping run clears tone in the same edge, so a release beats a toggle.
    always_comb begin
        w_run = 1'b1;
        case (r_state)
            IDLE:    w_run = 1'b0;
            PLAY:    w_run = w_any_key || sustain_en;
            STOP:    w_run = w_any_key || w_tone;
            default: w_run = 1'b1;
        endcase
    end

    assign w_tone_next = !w_run ? 1'b0 : (w_toggle ? ~w_tone : w_tone);

    tone_divider #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .run    (w_run),
        .hp_in  (w_hp_in),
        .tone   (w_tone),
        .toggle (w_toggle)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_key_q    <= '0;
            r_mute_q   <= 1'b0;
            r_piezo    <= 1'b0;
            r_active   <= 1'b0;
            r_note_idx <= '0;
            r_sus      <= '0;
        end else begin
            r_key_q  <= keys;
            r_mute_q <= mute;
            r_piezo  <= w_tone_next & ~r_mute_q;
            if (w_load) r_note_idx <= w_idx;
            case (r_state)
                IDLE: begin
                    if (w_any_key) begin
                        r_state  <= PLAY;
                        r_active <= 1'b1;
                    end
                end
                PLAY: begin
                    if (!w_any_key) begin
                        if (sustain_en) begin
                            r_state <= SUSTAIN;
                            r_sus   <= '0;
                        end else begin
                            r_state  <= IDLE;
                            r_active <= 1'b0;
                        end
                    end
                end
                SUSTAIN: begin
                    r_sus <= r_sus + SUS_W'(1);
                    if (w_any_key)                r_state <= PLAY;
                    else if (r_sus == c_sus_last) r_state <= STOP;
                end
                STOP: begin
                    // Finish only on a low level so the last high half is never cut.
                    if (w_any_key) begin
                        r_state <= PLAY;
                    end else if (!w_tone || w_toggle) begin
                        r_state  <= IDLE;
                        r_active <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign piezo    = r_piezo;
    assign active   = r_active;
    assign note_idx = r_note_idx;

endmodule
`default_nettype wire

// File: tb/tb_piano_synth.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piano_synth
//  Description : Scoreboard bench: expected piezo/active edges are queued by
//                the stimulus and matched by a monitor as the DUT produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piano_synth;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] keys = 8'h00;
    logic [1:0] octave = 2'd0;
    logic       sustain_en = 1'b0;
    logic       mute = 1'b0;
    logic       piezo;
    logic       active;
    logic [2:0] note_idx;

    piano_synth #(
        .NUM_KEYS    (8),
        .CNT_W       (16),
        .SUSTAIN_CYC (5000),
        .SUS_W       (22)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .keys       (keys),
        .octave     (octave),
        .sustain_en (sustain_en),
        .mute       (mute),
        .piezo      (piezo),
        .active     (active),
        .note_idx   (note_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic       p;
        logic       a;
        logic [2:0] n;
    } ev_t;

    ev_t  sb[$];
    ev_t  mon_ev;
    int   n_vec = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;
    logic prev_p = 1'b0;
    logic prev_a = 1'b0;

    task automatic expect_ev(input int at, input logic p, input logic a, input logic [2:0] n);
        ev_t e;
        e.at = at;
        e.p  = p;
        e.a  = a;
        e.n  = n;
        sb.push_back(e);
    endtask

    task automatic tone_edges(input int first, input int half, input int count,
                              input logic first_level, input logic [2:0] n);
        for (int i = 0; i < count; i++)
            expect_ev(first + i * half, (i % 2 == 0) ? first_level : ~first_level, 1'b1, n);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d (edge %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Every change of piezo or active is an output event matched in order.
    always @(negedge clk) begin
        if (mon_en && (piezo !== prev_p || active !== prev_a)) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: edge %0d piezo=%b active=%b note=%0d, required no event",
                         cyc, piezo, active, note_idx);
            end else begin
                mon_ev = sb.pop_front();
                if (cyc != mon_ev.at || piezo !== mon_ev.p || active !== mon_ev.a || note_idx !== mon_ev.n) begin
                    n_err++;
                    $display("FAIL event: got edge %0d piezo=%b active=%b note=%0d, required edge %0d piezo=%b active=%b note=%0d",
                             cyc, piezo, active, note_idx, mon_ev.at, mon_ev.p, mon_ev.a, mon_ev.n);
                end
            end
            prev_p = piezo;
            prev_a = active;
        end
    end

    initial begin
        int p;
        repeat (3) @(negedge clk);
        chk("reset_piezo", int'(piezo), 0);
        chk("reset_active", int'(active), 0);
        chk("reset_note_idx", int'(note_idx), 0);
        reset = 1'b0;
        @(negedge clk);
        prev_p = piezo;
        prev_a = active;
        mon_en = 1'b1;

        // Basic tone, key 0: half 1912, first rise 1914 edges after the key edge
        p = cyc;
        expect_ev(p + 2, 1'b0, 1'b1, 3'd0);
        tone_edges(p + 1914, 1912, 3, 1'b1, 3'd0);
        expect_ev(p + 6002, 1'b0, 1'b0, 3'd0);
        keys = 8'h01;
        wait_until(p + 6000); keys = 8'h00;
        wait_until(p + 6010);

        // Priority + octave: keys 2 and 7 pressed, octave 2 -> half 380
        p = cyc;
        expect_ev(p + 2, 1'b0, 1'b1, 3'd2);
        tone_edges(p + 382, 380, 4, 1'b1, 3'd2);
        expect_ev(p + 1602, 1'b0, 1'b0, 3'd2);
        octave = 2'd2;
        keys   = 8'h84;
        wait_until(p + 1600); keys = 8'h00;
        wait_until(p + 1610); octave = 2'd0;

        // Glitch-free change: key 7 -> key 0 during a high half
        p = cyc;
        expect_ev(p + 2, 1'b0, 1'b1, 3'd7);
        expect_ev(p + 958, 1'b1, 1'b1, 3'd7);
        expect_ev(p + 1914, 1'b0, 1'b1, 3'd0);
        tone_edges(p + 3826, 1912, 2, 1'b1, 3'd0);
        expect_ev(p + 5802, 1'b0, 1'b0, 3'd0);
        keys = 8'h80;
        wait_until(p + 1300); keys = 8'h01;
        wait_until(p + 5800); keys = 8'h00;
        wait_until(p + 5810);

        // Sustain tail: key 4 released while high, tail ends on the falling toggle
        p = cyc;
        expect_ev(p + 2, 1'b0, 1'b1, 3'd4);
        tone_edges(p + 1278, 1276, 7, 1'b1, 3'd4);
        expect_ev(p + 10210, 1'b0, 1'b0, 3'd4);
        sustain_en = 1'b1;
        keys = 8'h10;
        wait_until(p + 4000); keys = 8'h00;
        wait_until(p + 7000); chk("sustain_active", int'(active), 1);
        wait_until(p + 10220); sustain_en = 1'b0;

        // Mute while playing, then release without sustain while high
        p = cyc;
        expect_ev(p + 2, 1'b0, 1'b1, 3'd0);
        expect_ev(p + 1914, 1'b1, 1'b1, 3'd0);
        expect_ev(p + 2502, 1'b0, 1'b1, 3'd0);
        expect_ev(p + 3002, 1'b1, 1'b1, 3'd0);
        expect_ev(p + 3826, 1'b0, 1'b1, 3'd0);
        expect_ev(p + 5738, 1'b1, 1'b1, 3'd0);
        expect_ev(p + 6002, 1'b0, 1'b0, 3'd0);
        keys = 8'h01;
        wait_until(p + 2500); mute = 1'b1;
        wait_until(p + 2800);
        chk("mute_piezo", int'(piezo), 0);
        chk("mute_active", int'(active), 1);
        wait_until(p + 3000); mute = 1'b0;
        wait_until(p + 6000); keys = 8'h00;
        wait_until(p + 6010);

        // Release coinciding with a toggle: release wins, no rise
        p = cyc;
        expect_ev(p + 2, 1'b0, 1'b1, 3'd7);
        expect_ev(p + 958, 1'b1, 1'b1, 3'd7);
        expect_ev(p + 1914, 1'b0, 1'b1, 3'd7);
        expect_ev(p + 2870, 1'b0, 1'b0, 3'd7);
        keys = 8'h80;
        wait_until(p + 2868); keys = 8'h00;
        wait_until(p + 2880);

        // Reset mid-note with key held, then clean restart
        p = cyc;
        expect_ev(p + 2, 1'b0, 1'b1, 3'd0);
        expect_ev(p + 1914, 1'b1, 1'b1, 3'd0);
        expect_ev(p + 2001, 1'b0, 1'b0, 3'd0);
        expect_ev(p + 2005, 1'b0, 1'b1, 3'd0);
        expect_ev(p + 3917, 1'b1, 1'b1, 3'd0);
        expect_ev(p + 4002, 1'b0, 1'b0, 3'd0);
        keys = 8'h01;
        wait_until(p + 2000); reset = 1'b1;
        wait_until(p + 2003); reset = 1'b0;
        wait_until(p + 4000); keys = 8'h00;
        wait_until(p + 4020);

        chk("missing_events", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
